// File: rtl/cpu_pkg.sv
// Shared encodings for the RV64 multi-cycle sequencer: FSM states, trap causes, CSR/priv constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] EXC_IACCESS = 4'd1;
  localparam logic [3:0] EXC_LACCESS = 4'd5;
  localparam logic [3:0] EXC_SACCESS = 4'd7;

  localparam logic [1:0]  PRIV_U      = 2'b00;
  localparam logic [1:0]  PRIV_M      = 2'b11;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Index width for an N-way selector; never zero so single-source instances stay legal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_prio_sel.sv
// Fixed-priority selector: reports whether any request is set and the index of the winner.
module prio_sel
  import cpu_pkg::*;
#(
  parameter  int N          = 4,
  parameter  bit HIGH_FIRST = 1'b0,
  localparam int IW         = sel_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Later assignments override earlier ones, so scan towards the preferred end.
    for (int i = 0; i < N; i++) begin
      if (HIGH_FIRST) begin
        if (req[i]) idx = IW'(i);
      end else if (req[N-1-i]) begin
        idx = IW'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with exception/interrupt arbitration.
// Optional memory wait-state timeout enabled by defining CPU_SEQ_MEM_TMO_EN.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int N_EXC   = 5,
  parameter int N_IRQ   = 3,
  parameter int MEM_TMO = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  input  logic                  imem_ack,
  output logic                  dmem_req,
  input  logic                  dmem_ack,
  input  logic                  is_LOAD,
  input  logic                  is_STORE,
  input  logic                  mret,
  input  logic [XLEN-1:0]       pc_addr,
  input  logic [XLEN-1:0]       dmem_addr,
  input  logic [N_EXC-1:0]      exc_en_vec,
  input  logic [4*N_EXC-1:0]    exc_code_vec,
  input  logic [XLEN*N_EXC-1:0] exc_val_vec,
  input  logic [N_IRQ-1:0]      irq_pending,
  input  logic [4*N_IRQ-1:0]    irq_code_vec,
  input  logic                  mstatus_mie,
  output logic                  pc_en,
  output logic                  we_regs_gate,
  output logic                  we_dmem_gate,
  output logic                  we_csr_gate,
  output logic                  instr_retired,
  output logic                  exc_en,
  output logic [3:0]            exc_code,
  output logic [XLEN-1:0]       exc_val,
  output logic                  irq_en,
  output logic [3:0]            irq_code,
  output logic [2:0]            state
);

  state_t                  state_q, state_d;
  logic                    fetch_busy_q;
  logic                    trap_irq_q, trap_irq_d;
  logic [3:0]              exc_code_q, exc_code_d, irq_code_q, irq_code_d;
  logic [XLEN-1:0]         exc_val_q, exc_val_d;
  logic                    exc_any, irq_any, irq_take, tmo_hit;
  logic [sel_w(N_EXC)-1:0] exc_idx;
  logic [sel_w(N_IRQ)-1:0] irq_idx;

  prio_sel #(.N(N_EXC), .HIGH_FIRST(1'b0)) u_exc_sel (
    .req(exc_en_vec), .valid(exc_any), .idx(exc_idx)
  );

  prio_sel #(.N(N_IRQ), .HIGH_FIRST(1'b1)) u_irq_sel (
    .req(irq_pending), .valid(irq_any), .idx(irq_idx)
  );

  // Interrupts are only considered on the first FETCH cycle, before imem_req rises.
  assign irq_take = irq_any && mstatus_mie && !fetch_busy_q;

`ifdef CPU_SEQ_MEM_TMO_EN
  localparam int TW = $clog2(MEM_TMO + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          waiting;

  always_comb begin
    waiting = 1'b0;
    if (state_q == ST_FETCH)    waiting = !irq_take && !imem_ack;
    else if (state_q == ST_MEM) waiting = !dmem_ack;
  end

  assign tmo_hit = waiting && (wait_cnt_q == TW'(MEM_TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          wait_cnt_q <= '0;
    else if (state_q != ST_FETCH && state_q != ST_MEM) wait_cnt_q <= '0;
    else if (waiting)                                 wait_cnt_q <= wait_cnt_q + TW'(1);
  end
`else
  logic unused_ok;
  assign unused_ok = MEM_TMO[0];
  assign tmo_hit   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      fetch_busy_q <= 1'b0;
      trap_irq_q   <= 1'b0;
      exc_code_q   <= '0;
      exc_val_q    <= '0;
      irq_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_busy_q <= (state_q == ST_FETCH) && (state_d == ST_FETCH);
      trap_irq_q   <= trap_irq_d;
      exc_code_q   <= exc_code_d;
      exc_val_q    <= exc_val_d;
      irq_code_q   <= irq_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    trap_irq_d    = trap_irq_q;
    exc_code_d    = exc_code_q;
    exc_val_d     = exc_val_q;
    irq_code_d    = irq_code_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    pc_en         = 1'b0;
    we_regs_gate  = 1'b0;
    we_dmem_gate  = 1'b0;
    we_csr_gate   = 1'b0;
    instr_retired = 1'b0;
    exc_en        = 1'b0;
    irq_en        = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (irq_take) begin
          state_d    = ST_TRAP;
          trap_irq_d = 1'b1;
          irq_code_d = irq_code_vec[4*int'(irq_idx) +: 4];
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            state_d = ST_DECODE;
          end else if (tmo_hit) begin
            state_d    = ST_TRAP;
            trap_irq_d = 1'b0;
            exc_code_d = EXC_IACCESS;
            exc_val_d  = pc_addr;
          end
        end
      end
      ST_DECODE, ST_EXEC: begin
        if (exc_any) begin
          state_d    = ST_TRAP;
          trap_irq_d = 1'b0;
          exc_code_d = exc_code_vec[4*int'(exc_idx) +: 4];
          exc_val_d  = exc_val_vec[XLEN*int'(exc_idx) +: XLEN];
        end else if (state_q == ST_DECODE) begin
          state_d = ST_EXEC;
        end else if (is_LOAD || is_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req     = 1'b1;
        we_dmem_gate = is_STORE;
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (tmo_hit) begin
          state_d    = ST_TRAP;
          trap_irq_d = 1'b0;
          exc_code_d = is_STORE ? EXC_SACCESS : EXC_LACCESS;
          exc_val_d  = dmem_addr;
        end
      end
      ST_WB: begin
        // mret retires like any other instruction; trap_handler performs the pc redirect.
        we_regs_gate  = 1'b1;
        we_csr_gate   = 1'b1;
        pc_en         = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_TRAP: begin
        pc_en   = 1'b1;
        exc_en  = !trap_irq_q;
        irq_en  = trap_irq_q;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (rst) begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      pc_en         = 1'b0;
      we_regs_gate  = 1'b0;
      we_dmem_gate  = 1'b0;
      we_csr_gate   = 1'b0;
      instr_retired = 1'b0;
      exc_en        = 1'b0;
      irq_en        = 1'b0;
    end
  end

  logic unused_mret;
  assign unused_mret = mret;

  assign state    = state_q;
  assign exc_code = exc_code_q;
  assign exc_val  = exc_val_q;
  assign irq_code = irq_code_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: randomized instruction flows against a trap/retire event model.
// Build with CPU_SEQ_MEM_TMO_EN defined to exercise the memory timeout path.
module tb_cpu_seq_ctrl;

  localparam int XLEN    = 64;
  localparam int N_EXC   = 5;
  localparam int N_IRQ   = 3;
  localparam int MEM_TMO = 15;
  localparam int EV_RET  = 0;
  localparam int EV_EXC  = 1;
  localparam int EV_IRQ  = 2;

  typedef struct {
    int              kind;
    logic [3:0]      code;
    logic [XLEN-1:0] val;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  imem_req, imem_ack, dmem_req, dmem_ack;
  logic                  is_LOAD, is_STORE, mret;
  logic [XLEN-1:0]       pc_addr, dmem_addr;
  logic [N_EXC-1:0]      exc_en_vec;
  logic [4*N_EXC-1:0]    exc_code_vec;
  logic [XLEN*N_EXC-1:0] exc_val_vec;
  logic [N_IRQ-1:0]      irq_pending;
  logic [4*N_IRQ-1:0]    irq_code_vec;
  logic                  mstatus_mie;
  logic                  pc_en, we_regs_gate, we_dmem_gate, we_csr_gate, instr_retired;
  logic                  exc_en, irq_en;
  logic [3:0]            exc_code, irq_code;
  logic [XLEN-1:0]       exc_val;
  logic [2:0]            state;

  cpu_seq_ctrl #(.XLEN(XLEN), .N_EXC(N_EXC), .N_IRQ(N_IRQ), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .is_LOAD(is_LOAD), .is_STORE(is_STORE), .mret(mret),
    .pc_addr(pc_addr), .dmem_addr(dmem_addr),
    .exc_en_vec(exc_en_vec), .exc_code_vec(exc_code_vec), .exc_val_vec(exc_val_vec),
    .irq_pending(irq_pending), .irq_code_vec(irq_code_vec), .mstatus_mie(mstatus_mie),
    .pc_en(pc_en), .we_regs_gate(we_regs_gate), .we_dmem_gate(we_dmem_gate),
    .we_csr_gate(we_csr_gate), .instr_retired(instr_retired),
    .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
    .irq_en(irq_en), .irq_code(irq_code), .state(state)
  );

  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_pass = 0;
  int  quiet_viol = 0;
  ev_t exp_q[$];
  ev_t mon_e;
  int  mon_kind;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Interrupt model: the highest-numbered pending line wins.
  function automatic logic [3:0] irq_pick(input logic [N_IRQ-1:0] p, input logic [4*N_IRQ-1:0] codes);
    for (int i = N_IRQ - 1; i >= 0; i--) if (p[i]) return codes[4*i +: 4];
    return 4'd0;
  endfunction

  // Exception model: the lowest-numbered flagged source wins.
  function automatic int exc_first(input logic [N_EXC-1:0] v);
    for (int i = 0; i < N_EXC; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic raise_exc(input logic [N_EXC-1:0] evec);
    ev_t e;
    int  w;
    exc_en_vec   = evec;
    exc_code_vec = 20'($urandom);
    for (int i = 0; i < N_EXC; i++) exc_val_vec[XLEN*i +: XLEN] = {$urandom, $urandom};
    w      = exc_first(evec);
    e.kind = EV_EXC;
    e.code = exc_code_vec[4*w +: 4];
    e.val  = exc_val_vec[XLEN*w +: XLEN];
    exp_q.push_back(e);
    @(negedge clk);
    exc_en_vec = '0;
    chk("exc_trap_state", 64'(state), 64'(5));
    @(negedge clk);
  endtask

  // Called on the first FETCH cycle; returns on the first FETCH cycle of the next instruction.
  task automatic run_instr(input logic [N_IRQ-1:0] irq, input logic mie, input int fd,
                           input int op, input int md, input int exc_at,
                           input logic [N_EXC-1:0] evec);
    ev_t e;
    irq_pending  = irq;
    mstatus_mie  = mie;
    irq_code_vec = 12'($urandom);
    is_LOAD      = (op == 1);
    is_STORE     = (op == 2);
    pc_addr      = {$urandom, $urandom};
    dmem_addr    = {$urandom, $urandom};
    exc_en_vec   = '0;
    #1;
    chk("fetch_entry_state", 64'(state), 64'(0));
    if (mie && irq != '0) begin
      e.kind = EV_IRQ;
      e.code = irq_pick(irq, irq_code_vec);
      e.val  = '0;
      exp_q.push_back(e);
      chk("irq_no_imem_req", 64'(imem_req), 64'(0));
      @(negedge clk);
      chk("irq_trap_state", 64'(state), 64'(5));
      irq_pending = '0;
      @(negedge clk);
      return;
    end
    for (int k = 0; k <= fd; k++) begin
      imem_ack = (k == fd);
      if (k == 1) begin
        irq_pending = N_IRQ'($urandom_range(1, 7));
        mstatus_mie = 1'b1;
      end
      #1 chk("imem_req_held", 64'(imem_req), 64'(1));
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("decode_state", 64'(state), 64'(1));
    if (exc_at == 1) begin
      raise_exc(evec);
      return;
    end
    @(negedge clk);
    chk("exec_state", 64'(state), 64'(2));
    if (exc_at == 2) begin
      raise_exc(evec);
      return;
    end
    e.kind = EV_RET;
    e.code = '0;
    e.val  = '0;
    exp_q.push_back(e);
    if (op != 0) begin
      @(negedge clk);
      chk("mem_state", 64'(state), 64'(3));
      for (int k = 0; k <= md; k++) begin
        dmem_ack = (k == md);
        #1;
        chk("dmem_req_held", 64'(dmem_req), 64'(1));
        chk("we_dmem_gate", 64'(we_dmem_gate), 64'(op == 2));
        @(negedge clk);
      end
      dmem_ack = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk("wb_state", 64'(state), 64'(4));
    @(negedge clk);
  endtask

  task automatic reach_mem(input int op);
    irq_pending = '0;
    mstatus_mie = 1'b0;
    is_LOAD     = (op == 1);
    is_STORE    = (op == 2);
    dmem_addr   = {$urandom, $urandom};
    exc_en_vec  = '0;
    imem_ack    = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_mem_state", 64'(state), 64'(3));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (instr_retired || exc_en || irq_en) begin
        chk("event_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_e    = exp_q.pop_front();
          mon_kind = instr_retired ? EV_RET : (exc_en ? EV_EXC : EV_IRQ);
          chk("event_kind", 64'(mon_kind), 64'(mon_e.kind));
          chk("exc_irq_exclusive", 64'(exc_en & irq_en), 64'(0));
          if (mon_e.kind == EV_EXC) begin
            chk("exc_code", 64'(exc_code), 64'(mon_e.code));
            chk("exc_val", exc_val, mon_e.val);
          end else if (mon_e.kind == EV_IRQ) begin
            chk("irq_code", 64'(irq_code), 64'(mon_e.code));
          end
          if (mon_e.kind == EV_RET)
            chk("retire_gates", 64'({we_regs_gate, we_csr_gate, pc_en, we_dmem_gate}), 64'(4'b1110));
          else
            chk("trap_gates", 64'({we_regs_gate, we_csr_gate, pc_en, we_dmem_gate, instr_retired}),
                64'(5'b00100));
        end
      end else if (pc_en || we_regs_gate || we_csr_gate) begin
        quiet_viol++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int              fd, op, md, ea, r;
    logic [N_IRQ-1:0] irq;
    logic            mie;
    logic [N_EXC-1:0] ev;
`ifdef CPU_SEQ_MEM_TMO_EN
    ev_t             te;
    int              req_cycles;
`endif
    imem_ack = 1'b0; dmem_ack = 1'b0; is_LOAD = 1'b0; is_STORE = 1'b0; mret = 1'b0;
    pc_addr = '0; dmem_addr = '0; exc_en_vec = '0; exc_code_vec = '0; exc_val_vec = '0;
    irq_pending = '0; irq_code_vec = '0; mstatus_mie = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_outputs", 64'({imem_req, dmem_req, pc_en, we_regs_gate, we_csr_gate, we_dmem_gate,
                            instr_retired, exc_en, irq_en}), 64'(0));
    chk("rst_codes", 64'({exc_code, irq_code}), 64'(0));
    chk("rst_exc_val", exc_val, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_instr('0, 1'b0, 2, 0, 0, 0, '0);
    run_instr('0, 1'b0, 1, 1, 3, 0, '0);
    run_instr('0, 1'b1, 0, 0, 0, 1, 5'b10100);
    run_instr(3'b011, 1'b1, 0, 0, 0, 0, '0);
    run_instr(3'b011, 1'b0, 1, 2, 1, 0, '0);

    for (int n = 0; n < 60; n++) begin
      r   = $urandom_range(0, 9);
      irq = (r < 3) ? N_IRQ'($urandom_range(1, 7)) : '0;
      mie = 1'($urandom);
      fd  = $urandom_range(0, 3);
      op  = $urandom_range(0, 2);
      md  = $urandom_range(0, 3);
      r   = $urandom_range(0, 5);
      ea  = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      ev  = N_EXC'($urandom_range(1, 31));
      run_instr(irq, mie, fd, op, md, ea, ev);
    end

    reach_mem(2);
`ifdef CPU_SEQ_MEM_TMO_EN
    te.kind = EV_EXC;
    te.code = 4'd7;
    te.val  = dmem_addr;
    exp_q.push_back(te);
    req_cycles = 0;
    for (int k = 0; k < 40 && state == 3'd3; k++) begin
      if (dmem_req) req_cycles++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 64'(req_cycles), 64'(MEM_TMO));
    chk("tmo_trap_state", 64'(state), 64'(5));
    @(negedge clk);
    reach_mem(1);
    repeat (2) @(negedge clk);
`else
    repeat (20) @(negedge clk);
    chk("stall_mem_state_held", 64'(state), 64'(3));
    chk("stall_dmem_req", 64'(dmem_req), 64'(1));
`endif

    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", 64'({imem_req, dmem_req, pc_en, we_regs_gate, we_csr_gate, we_dmem_gate,
                                  instr_retired, exc_en, irq_en}), 64'(0));
    chk("async_rst_state", 64'(state), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_state", 64'(state), 64'(0));
    chk("post_rst_imem_req", 64'(imem_req), 64'(1));
    run_instr('0, 1'b0, 0, 0, 0, 0, '0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("quiet_gate_violations", 64'(quiet_viol), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
